// File: rtl/background_index_reader_if.sv
// Memory read port plus outgoing index stream for background_index_reader.
// master = the reader; slave = memory / index consumer side.
`timescale 1ns/1ps
interface background_index_reader_if #(
  parameter int IDX_W = 4
);
  logic [5:0]       m_address;
  logic             m_chipselect;
  logic             m_clken;
  logic             m_write;
  logic [31:0]      m_writedata;
  logic [3:0]       m_byteenable;
  logic             m_debugaccess;
  logic [31:0]      m_readdata;
  logic             idx_valid;
  logic             idx_ready;
  logic [IDX_W-1:0] idx_data;
  logic             idx_last;

  modport master (
    output m_address, m_chipselect, m_clken, m_write, m_writedata,
           m_byteenable, m_debugaccess,
    input  m_readdata,
    output idx_valid, idx_data, idx_last,
    input  idx_ready
  );

  modport slave (
    input  m_address, m_chipselect, m_clken, m_write, m_writedata,
           m_byteenable, m_debugaccess,
    output m_readdata,
    input  idx_valid, idx_data, idx_last,
    output idx_ready
  );
endinterface

// File: rtl/background_index_reader.sv
// Reads a block of 32-bit words and streams each as 32/IDX_W packed indices, LSB first.
// Per word: 1 READ + READ_LATENCY WAIT + 32/IDX_W UNPACK cycles; idx_ready low stalls UNPACK.
`timescale 1ns/1ps
module background_index_reader #(
  parameter int IDX_W        = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic       clk1_clk,
  input  logic       reset1_reset,
  input  logic       start,
  input  logic [5:0] base_addr,
  input  logic [6:0] word_count,
  output logic       busy,
  output logic       done,
  background_index_reader_if.master bus
);
  localparam int PER_WORD = 32 / IDX_W;
  localparam int CNT_W    = $clog2(PER_WORD);

  typedef enum logic [2:0] {IDLE, READ, WAIT, UNPACK, DONE} state_t;

  state_t           state;
  logic [5:0]       addr;
  logic [6:0]       words_left;
  logic [31:0]      shreg;
  logic [CNT_W-1:0] idx_cnt;
  logic             wait_cnt;
  logic             busy_q;
  logic             done_q;
  logic             cs_q;
  logic [5:0]       addr_q;
  logic             valid_q;
  logic [IDX_W-1:0] data_q;
  logic             last_q;

  assign busy              = busy_q;
  assign done              = done_q;
  assign bus.m_address     = addr_q;
  assign bus.m_chipselect  = cs_q;
  assign bus.m_clken       = 1'b1;
  assign bus.m_write       = 1'b0;
  assign bus.m_writedata   = 32'h0;
  assign bus.m_byteenable  = 4'hF;
  assign bus.m_debugaccess = 1'b0;
  assign bus.idx_valid     = valid_q;
  assign bus.idx_data      = data_q;
  assign bus.idx_last      = last_q;

  always_ff @(posedge clk1_clk or posedge reset1_reset) begin
    if (reset1_reset) begin
      state      <= IDLE;
      addr       <= 6'd0;
      words_left <= 7'd0;
      shreg      <= 32'h0;
      idx_cnt    <= '0;
      wait_cnt   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b0;
      addr_q     <= 6'd0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (word_count == 7'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state      <= READ;
              addr       <= base_addr;
              addr_q     <= base_addr;
              cs_q       <= 1'b1;
              words_left <= (word_count > 7'd64) ? 7'd64 : word_count;
            end
          end
        end
        READ: begin
          state    <= WAIT;
          cs_q     <= 1'b0;
          wait_cnt <= 1'b0;
        end
        WAIT: begin
          if (wait_cnt == 1'(READ_LATENCY - 1)) begin
            state   <= UNPACK;
            shreg   <= bus.m_readdata;
            data_q  <= bus.m_readdata[IDX_W-1:0];
            valid_q <= 1'b1;
            idx_cnt <= '0;
            // A word always holds at least two indices, so its first one is never last.
            last_q  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        UNPACK: begin
          if (bus.idx_ready) begin
            shreg <= shreg >> IDX_W;
            if (idx_cnt == CNT_W'(PER_WORD - 1)) begin
              valid_q    <= 1'b0;
              last_q     <= 1'b0;
              addr       <= addr + 6'd1;
              words_left <= words_left - 7'd1;
              if (words_left == 7'd1) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state  <= READ;
                cs_q   <= 1'b1;
                addr_q <= addr + 6'd1;
              end
            end else begin
              data_q  <= shreg[2*IDX_W-1:IDX_W];
              idx_cnt <= idx_cnt + 1'b1;
              last_q  <= (words_left == 7'd1) && (idx_cnt == CNT_W'(PER_WORD - 2));
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_background_index_reader.sv
// Directed bench: latency-1 and latency-2 instances share stimulus, selected by sel.
`timescale 1ns/1ps
module tb_background_index_reader;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, idx_ready, sel;
  logic [5:0] base;
  logic [6:0] cnt;
  logic       busy0, done0, busy1, done1;

  background_index_reader_if #(.IDX_W(IDX_W)) bus0();
  background_index_reader_if #(.IDX_W(IDX_W)) bus1();

  background_index_reader #(.IDX_W(IDX_W), .READ_LATENCY(1)) u0 (
    .clk1_clk(clk), .reset1_reset(rst), .start(start & ~sel), .base_addr(base),
    .word_count(cnt), .busy(busy0), .done(done0), .bus(bus0.master));

  background_index_reader #(.IDX_W(IDX_W), .READ_LATENCY(2)) u1 (
    .clk1_clk(clk), .reset1_reset(rst), .start(start & sel), .base_addr(base),
    .word_count(cnt), .busy(busy1), .done(done1), .bus(bus1.master));

  // Memory models: junk unless a read was strobed, so a mistimed capture shows up.
  logic [31:0] mem [64];
  logic [31:0] rd0, s1, rd1;
  always @(posedge clk) begin
    rd0 <= bus0.m_chipselect ? mem[bus0.m_address] : 32'hDEAD_BEEF;
    s1  <= bus1.m_chipselect ? mem[bus1.m_address] : 32'hDEAD_BEEF;
    rd1 <= s1;
  end
  assign bus0.m_readdata = rd0;
  assign bus1.m_readdata = rd1;
  assign bus0.idx_ready  = idx_ready;
  assign bus1.idx_ready  = idx_ready;

  logic             busy_s, done_s, cs_s, vld_s, last_s;
  logic [5:0]       addr_s;
  logic [IDX_W-1:0] dat_s;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign cs_s   = sel ? bus1.m_chipselect : bus0.m_chipselect;
  assign vld_s  = sel ? bus1.idx_valid : bus0.idx_valid;
  assign last_s = sel ? bus1.idx_last : bus0.idx_last;
  assign addr_s = sel ? bus1.m_address : bus0.m_address;
  assign dat_s  = sel ? bus1.idx_data : bus0.idx_data;

  // Monitor: records reads, handshakes, done pulses and protocol errors at negedge.
  int cyc = 0, done_cnt = 0, busy_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  int stab_err = 0, hold_err = 0;
  logic [5:0]   rd_q[$];
  logic [IDX_W:0] ix_q[$];
  logic           prev_stall = 1'b0;
  logic [IDX_W:0] prev_ix = '0;
  logic [5:0]     last_cs_addr = 6'd0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      last_cs_addr <= 6'd0;
    end else begin
      if (cs_s) begin
        rd_q.push_back(addr_s);
        last_cs_addr <= addr_s;
      end else if (busy_s && addr_s !== last_cs_addr) begin
        hold_err <= hold_err + 1;
      end
      if (vld_s && idx_ready) begin
        ix_q.push_back({last_s, dat_s});
        last_hs_cyc <= cyc;
      end
      if (prev_stall && (!vld_s || {last_s, dat_s} !== prev_ix))
        stab_err <= stab_err + 1;
      if (done_s) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (busy_s) busy_cyc <= busy_cyc + 1;
    end
    prev_stall <= vld_s && !idx_ready;
    prev_ix    <= {last_s, dat_s};
  end

  int n_vec = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_s), 0);
    chk({tag, "_done"}, 32'(done_s), 0);
    chk({tag, "_cs"}, 32'(cs_s), 0);
    chk({tag, "_valid"}, 32'(vld_s), 0);
    chk({tag, "_last"}, 32'(last_s), 0);
    chk({tag, "_addr"}, 32'(addr_s), 0);
    chk({tag, "_data"}, 32'(dat_s), 0);
  endtask

  // Expected stream: word i at (b+i)%64, nibbles LSB first, last only on the final one.
  task automatic check_stream(input string tag, input int b, input int nw, input int rb, input int ib);
    int a, e;
    logic [31:0] w;
    chk({tag, "_reads"}, rd_q.size() - rb, nw);
    for (int i = 0; i < nw && rb + i < rd_q.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), 32'(rd_q[rb + i]), (b + i) % 64);
    chk({tag, "_indices"}, ix_q.size() - ib, nw * 8);
    for (int i = 0; i < nw * 8 && ib + i < ix_q.size(); i++) begin
      a = (b + i / 8) % 64;
      w = mem[a];
      e = int'((w >> (4 * (i % 8))) & 32'hF) + ((i == nw * 8 - 1) ? 16 : 0);
      chk($sformatf("%s_idx%0d", tag, i), 32'(ix_q[ib + i]), e);
    end
  endtask

  typedef struct {
    bit         sel;
    logic [5:0] base;
    logic [6:0] cnt;
    bit         tog;
    int         exp_busy;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    int rb, ib, db, bb, sb, hb, nw;
    bit got;
    rb = rd_q.size(); ib = ix_q.size(); db = done_cnt;
    bb = busy_cyc; sb = stab_err; hb = hold_err;
    idx_ready = 1'b1;
    sel = v.sel; base = v.base; cnt = v.cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (v.tog) idx_ready = ~idx_ready;
      @(posedge clk); #1;
      if (done_cnt != db && !busy_s) begin
        got = 1'b1;
        break;
      end
    end
    idx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nw = (v.cnt > 64) ? 64 : int'(v.cnt);
    chk({tag, "_finished"}, 32'(got), 1);
    check_stream(tag, int'(v.base), nw, rb, ib);
    chk({tag, "_done_pulses"}, done_cnt - db, 1);
    if (v.exp_busy >= 0) chk({tag, "_busy_cycles"}, busy_cyc - bb, v.exp_busy);
    if (nw > 0) chk({tag, "_done_gap"}, done_cyc - last_hs_cyc, 1);
    chk({tag, "_stall_stable"}, stab_err - sb, 0);
    chk({tag, "_addr_hold"}, hold_err - hb, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int rb, ib, db, bb;
    bit got;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1) * 32'h9E37_79B1;
    mem[5] = 32'h7654_3210;

    vecs[0] = '{1'b0, 6'd5,  7'd1,   1'b0, 11};
    vecs[1] = '{1'b0, 6'd63, 7'd2,   1'b0, 21};
    vecs[2] = '{1'b0, 6'd5,  7'd1,   1'b1, -1};
    vecs[3] = '{1'b0, 6'd20, 7'd3,   1'b0, 31};
    vecs[4] = '{1'b0, 6'd0,  7'd0,   1'b0, 1};
    vecs[5] = '{1'b0, 6'd7,  7'd100, 1'b0, 641};
    vecs[6] = '{1'b1, 6'd5,  7'd1,   1'b0, 12};
    vecs[7] = '{1'b1, 6'd62, 7'd3,   1'b0, 34};

    rst = 1'b1; start = 1'b0; base = 6'd0; cnt = 7'd0; idx_ready = 1'b1; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst0");
    sel = 1'b1;
    chk_zero("rst1");
    sel = 1'b0;
    chk("clken", 32'(bus0.m_clken), 1);
    chk("write", 32'(bus0.m_write), 0);
    chk("writedata", bus0.m_writedata, 0);
    chk("byteenable", 32'(bus0.m_byteenable), 32'hF);
    chk("debugaccess", 32'(bus0.m_debugaccess), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset during UNPACK of word 2 of 4, then a fresh scan.
    db = done_cnt; ib = ix_q.size();
    sel = 1'b0; base = 6'd0; cnt = 7'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (ix_q.size() - ib >= 10) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid_reached", 32'(got), 1);
    chk("mid_valid", 32'(vld_s), 1);
    chk("mid_addr", 32'(addr_s), 1);
    #2 rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_no_done", done_cnt - db, 0);
    @(posedge clk); #1;
    run_vec("after_rst", '{1'b0, 6'd10, 7'd1, 1'b0, 11});

    // Latency 2: a start mid-scan and one in the DONE cycle are both ignored.
    rb = rd_q.size(); ib = ix_q.size(); db = done_cnt; bb = busy_cyc;
    sel = 1'b1; base = 6'd3; cnt = 7'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    base = 6'd40; cnt = 7'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_s) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("ign_finished", 32'(got), 1);
    check_stream("ign", 3, 2, rb, ib);
    chk("ign_done_pulses", done_cnt - db, 1);
    chk("ign_busy_cycles", busy_cyc - bb, 23);
    chk("ign_idle_after", 32'(busy_s), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/background_index_reader.md
BACKGROUND_INDEX_READER -- requirements
Module: background_index_reader

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning index width in bits; legal values 2, 4, 8, 16 (divides 32).
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning memory read latency in cycles; legal values 1 and 2.
REQ-003 SHALL have port clk1_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset1_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a scan.
REQ-006 SHALL have port base_addr, input, 6 bits: first word address, sampled with start.
REQ-007 SHALL have port word_count, input, 7 bits: number of words to read (0..64), sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a scan completes.
REQ-010 SHALL have port m_address, output, 6 bits: memory word address.
REQ-011 SHALL have port m_chipselect, output, 1 bit: read strobe to memory.
REQ-012 SHALL have ports m_clken (1), m_write (1), m_writedata (32), m_byteenable (4) and m_debugaccess (1), all outputs, driven constant 1, 0, 0, 4'hF and 0.
REQ-013 SHALL have port m_readdata, input, 32 bits: memory read data.
REQ-014 SHALL have ports idx_valid (output, 1), idx_ready (input, 1), idx_data (output, IDX_W) and idx_last (output, 1): the index stream.

Function
REQ-015 SHALL implement states IDLE, READ, WAIT, UNPACK and DONE.
REQ-016 In IDLE, start with word_count != 0 SHALL latch base_addr and word_count and go to READ; word_count > 64 SHALL be treated as 64.
REQ-017 In IDLE, start with word_count == 0 SHALL go to DONE without any memory access.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 READ SHALL last exactly one cycle with m_chipselect=1 and m_address equal to the current address, then go to WAIT.
REQ-020 WAIT SHALL last READ_LATENCY cycles and SHALL capture m_readdata into a 32-bit shift register at the end of its last cycle; m_chipselect SHALL be 0 throughout.
REQ-021 UNPACK SHALL drive idx_valid=1 and idx_data equal to the shift register bits [IDX_W-1:0], emitting the least-significant index first.
REQ-022 idx_data and idx_last SHALL hold stable while idx_valid=1 and idx_ready=0.
REQ-023 On each handshake (idx_valid and idx_ready both 1) the register SHALL shift right by IDX_W bits.
REQ-024 After the 32/IDX_W-th handshake of a word, the block SHALL go to READ if words remain, otherwise to DONE.
REQ-025 The current address SHALL increment by 1 per word, modulo 64 (63 wraps to 0).
REQ-026 idx_last SHALL be 1 only during the final index of the final word.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE; a start arriving in the DONE cycle SHALL be ignored.
REQ-028 busy SHALL be 1 in READ, WAIT, UNPACK and DONE, and 0 in IDLE.
REQ-029 m_address SHALL hold its last value when m_chipselect=0.
REQ-030 Per-word cost SHALL be 1 + READ_LATENCY + 32/IDX_W cycles when idx_ready is held at 1.

Reset
REQ-031 Reset assertion SHALL immediately force IDLE, with busy, done, idx_valid, idx_last and m_chipselect at 0, and m_address, idx_data and the shift register at 0.
REQ-032 Reset during a scan SHALL abandon the scan without a done pulse; the first start after reset release SHALL begin a fresh scan.

Verification
REQ-033 Basic scan: memory word 5 = 32'h76543210, IDX_W=4, READ_LATENCY=1, start with base 5 and count 1, idx_ready=1 -> one read at address 5; indices 0,1,...,7 on consecutive cycles; idx_last on 7; done one cycle later.
REQ-034 Wrap-around: start with base 63 and count 2 -> reads at addresses 63 then 0; 16 indices; idx_last only on the 16th index.
REQ-035 Backpressure: idx_ready toggled 1/0 every cycle -> idx_data stable during stalls; no index lost or duplicated; done asserted after the 8th handshake.
REQ-036 Zero count: start with count 0 -> no m_chipselect; done pulse 1 cycle after start; busy high for that one cycle.
REQ-037 Reset mid-scan: reset asserted during UNPACK of word 2 of 4 -> all outputs 0 at once, no done; a new start with base 10 and count 1 reads address 10.
REQ-038 Latency 2 and ignored start: READ_LATENCY=2, memory data delayed one extra cycle, start pulsed while busy -> captured data correct and the second start has no effect.
